// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and sizing helpers for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int c_def_ram_lat = 1;
    localparam int c_lat_cw      = $clog2(c_def_ram_lat + 1);

    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational grant picker; round-robin when MEM_ARB_RR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick (
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_last_winner,
    output logic o_grant_valid,
    output logic o_grant_owner
);
    import mem_arb_pkg::*;

    always_comb begin
        o_grant_valid = i_if_req | i_d_req;
        o_grant_owner = OWN_IF;
`ifdef MEM_ARB_RR_EN
        // A contested grant goes to whoever did not win last time.
        if (i_if_req && i_d_req) begin
            o_grant_owner = (i_last_winner == OWN_D) ? OWN_IF : OWN_D;
        end else if (i_d_req) begin
            o_grant_owner = OWN_D;
        end
`else
        if (i_d_req) begin
            o_grant_owner = OWN_D;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last_winner;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Single-port RAM arbiter for fetch and data access (MEM_ARB_RR_EN
//            selects round-robin priority instead of data-over-fetch).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_done,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_d_ld,
    input  logic          i_d_st,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_done,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_stall,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);
    import mem_arb_pkg::*;

    localparam int            CW         = lat_cnt_w(RAM_LAT);
    localparam logic [CW-1:0] c_cnt_init = CW'(RAM_LAT - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    owner_e        r_owner;
    logic          r_we;
    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_if_done;
    logic          r_d_done;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_d_req;
    logic          w_grant_valid;
    logic          w_grant_owner;
    logic          w_grant;
    logic          w_grant_we;
    logic          w_capture;
    logic          w_enter_resp;
    logic          w_last_winner;

    assign w_d_req = i_d_ld | i_d_st;

    mem_arb_pick u_pick (
        .i_if_req      (i_if_req),
        .i_d_req       (w_d_req),
        .i_last_winner (w_last_winner),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= OWN_IF;
        end else if (w_grant) begin
            r_last_winner <= w_grant_owner;
        end
    end

    assign w_last_winner = r_last_winner;
`else
    assign w_last_winner = OWN_IF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Both strobes high is a protocol error; the store wins.
    assign w_grant_we   = (w_grant_owner == OWN_D) & i_d_st;
    assign w_capture    = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_ram_en  <= w_grant;
            r_ram_we  <= w_grant & w_grant_we;
            r_if_done <= w_enter_resp & (r_owner == OWN_IF);
            r_d_done  <= w_enter_resp & (r_owner == OWN_D);
            if (w_grant) begin
                r_owner    <= owner_e'(w_grant_owner);
                r_we       <= w_grant_we;
                r_ram_addr <= (w_grant_owner == OWN_D) ? i_d_addr : i_if_addr;
                if (w_grant_owner == OWN_D) begin
                    r_ram_wdata <= i_d_wdata;
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_D) begin
                    r_d_rdata <= i_ram_rdata;
                end else begin
                    r_if_rdata <= i_ram_rdata;
                end
            end
        end
    end

    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_if_done   = r_if_done;
    assign o_d_done    = r_d_done;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_stall     = w_d_req & ~r_d_done;

endmodule
`default_nettype wire
